// File: rtl/bus_demux3x32.sv
// Write-side 3-way bus demux: captures IN into holding register A, B or C with byte enables,
// tracks unconsumed data per register and flags overwrite-before-consume and illegal selects.
module bus_demux3x32 #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        N_RST,
  input  logic [31:0] IN,
  input  logic [1:0]  SEL,
  input  logic        N_WE,
  input  logic [3:0]  BE,
  input  logic [2:0]  RD_ACK,
  input  logic        ERR_CLR,
  output logic [31:0] OUT_A,
  output logic [31:0] OUT_B,
  output logic [31:0] OUT_C,
  output logic [2:0]  N_LOAD,
  output logic [2:0]  FRESH,
  output logic [2:0]  OVR,
  output logic        ERR
);

  logic [31:0] data_q [3];
  logic [31:0] data_d [3];
  logic [2:0]  fresh_q, fresh_d;
  logic [2:0]  ovr_q, ovr_d;
  logic        err_q, err_d;
  logic [2:0]  wr;
  logic [31:0] be_mask;

  // 74139-style decode: one active-low strobe per legal select, none for SEL==11
  always_comb begin
    N_LOAD = 3'b111;
    for (int k = 0; k < 3; k++) begin
      if (!N_WE && (SEL == 2'(k))) N_LOAD[k] = 1'b0;
    end
  end

  assign wr      = ~N_LOAD;
  assign be_mask = {{8{BE[3]}}, {8{BE[2]}}, {8{BE[1]}}, {8{BE[0]}}};

  always_comb begin
    ovr_d = ERR_CLR ? 3'b000 : ovr_q;
    err_d = (ERR_CLR ? 1'b0 : err_q) | (!N_WE && (SEL == 2'b11));
    for (int k = 0; k < 3; k++) begin
      data_d[k]  = data_q[k];
      fresh_d[k] = fresh_q[k];
      if (wr[k]) begin
        data_d[k]  = (data_q[k] & ~be_mask) | (IN & be_mask);
        fresh_d[k] = 1'b1;
        // A same-edge ack means the old data was consumed, so this is not an overwrite
        if (fresh_q[k] && !RD_ACK[k]) ovr_d[k] = 1'b1;
      end else if (RD_ACK[k]) begin
        fresh_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      for (int k = 0; k < 3; k++) data_q[k] <= RESET_VAL;
      fresh_q <= 3'b000;
      ovr_q   <= 3'b000;
      err_q   <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) data_q[k] <= data_d[k];
      fresh_q <= fresh_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end

  assign OUT_A = data_q[0];
  assign OUT_B = data_q[1];
  assign OUT_C = data_q[2];
  assign FRESH = fresh_q;
  assign OVR   = ovr_q;
  assign ERR   = err_q;

`ifdef FORMAL
  a_full_a: assert property (@(posedge CLK) disable iff (!N_RST)
    (!N_WE && SEL == 2'd0 && BE == 4'hF) |=> (OUT_A == $past(IN)));
  a_full_b: assert property (@(posedge CLK) disable iff (!N_RST)
    (!N_WE && SEL == 2'd1 && BE == 4'hF) |=> (OUT_B == $past(IN)));
  a_full_c: assert property (@(posedge CLK) disable iff (!N_RST)
    (!N_WE && SEL == 2'd2 && BE == 4'hF) |=> (OUT_C == $past(IN)));
  a_illegal: assert property (@(posedge CLK) disable iff (!N_RST)
    (!N_WE && SEL == 2'd3) |=> ($stable(OUT_A) && $stable(OUT_B) && $stable(OUT_C)));
  a_onehot: assert property (@(posedge CLK) $countones(~N_LOAD) <= 1);
`endif

endmodule
